// File: rtl/fsm_mon_pkg.sv
// fsm_mon_pkg: shared types, default legal-state mask and saturating increment for the FSM trace monitor
package fsm_mon_pkg;
  typedef enum logic [1:0] {RD_IDLE, RD_LOOK, RD_ACK} rd_state_t;
  localparam logic [15:0] DEF_LEGAL_MASK = 16'h007E;
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] lim);
    return (v >= lim) ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter; ports clk, rst, clr (sync clear), en (count), q (value)
module sat_counter
  import fsm_mon_pkg::*;
#(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] q
);
  always_ff @(posedge clk)
    q <= (rst || clr) ? '0 : en ? CW'(sat_inc(32'(q), 32'({CW{1'b1}}))) : q;
endmodule

// File: rtl/fsm_trace_monitor.sv
// fsm_trace_monitor: passive state-bus observer; ports clk, rst, st_valid/st (sample), clear, rd_req/rd_idx/rd_ack/rd_count (count readback), visited, illegal, stuck, trans_cnt
module fsm_trace_monitor
  import fsm_mon_pkg::*;
#(
  parameter int                 SW         = 4,
  parameter int                 CW         = 8,
  parameter logic [2**SW-1:0]   LEGAL_MASK = DEF_LEGAL_MASK,
  parameter int                 STUCK_LIM  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             st_valid,
  input  logic [SW-1:0]    st,
  input  logic             clear,
  input  logic             rd_req,
  input  logic [SW-1:0]    rd_idx,
  output logic             rd_ack,
  output logic [CW-1:0]    rd_count,
  output logic [2**SW-1:0] visited,
  output logic             illegal,
  output logic             stuck,
  output logic [CW-1:0]    trans_cnt
);
  localparam int N  = 2**SW;
  localparam int HW = $clog2(STUCK_LIM + 1);
  logic [SW-1:0] prev, idx;
  logic          prev_vld, samp, entry, trans;
  logic [HW-1:0] hold, hold_nxt;
  logic [CW-1:0] cnt [N];
  rd_state_t     rd_state, rd_nxt;
  // clear wins over a same-cycle sample, so the sample is simply dropped
  always_comb begin
    samp     = st_valid && !clear;
    entry    = samp && (!prev_vld || st != prev);
    trans    = entry && prev_vld;
    hold_nxt = entry ? HW'(1) : HW'(sat_inc(32'(hold), STUCK_LIM));
  end
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      prev     <= '0;
      prev_vld <= 1'b0;
      hold     <= '0;
      visited  <= '0;
      illegal  <= 1'b0;
      stuck    <= 1'b0;
    end else if (samp) begin
      prev         <= st;
      prev_vld     <= 1'b1;
      hold         <= hold_nxt;
      visited[st]  <= 1'b1;
      illegal      <= illegal | !LEGAL_MASK[st];
      stuck        <= stuck | (32'(hold_nxt) >= STUCK_LIM);
    end
  end
  for (genvar i = 0; i < N; i++) begin : g_cnt
    sat_counter #(.CW(CW)) u_cnt (
      .clk (clk),
      .rst (rst),
      .clr (clear),
      .en  (entry && st == SW'(i)),
      .q   (cnt[i])
    );
  end
  sat_counter #(.CW(CW)) u_trans (
    .clk (clk),
    .rst (rst),
    .clr (clear),
    .en  (trans),
    .q   (trans_cnt)
  );
  always_comb
    rd_nxt = (rd_state == RD_IDLE) ? (rd_req ? RD_LOOK : RD_IDLE) :
             (rd_state == RD_LOOK) ? RD_ACK : RD_IDLE;
  // read FSM ignores clear; rd_count samples the registered count, i.e. before any same-cycle update
  always_ff @(posedge clk) begin
    rd_state <= rst ? RD_IDLE : rd_nxt;
    idx      <= (rd_state == RD_IDLE && rd_req) ? rd_idx : idx;
    rd_count <= rst ? '0 : (rd_state == RD_LOOK) ? cnt[idx] : rd_count;
  end
  assign rd_ack = (rd_state == RD_ACK);
endmodule

// File: tb/tb_fsm_trace_monitor.sv
// tb_fsm_trace_monitor: self-checking bench for fsm_trace_monitor
module tb_fsm_trace_monitor;
  logic        clk = 0, rst = 1, st_valid = 0, clear = 0, rd_req = 0;
  logic [3:0]  st = '0, rd_idx = '0;
  logic        rd_ack, illegal, stuck;
  logic [7:0]  rd_count, trans_cnt;
  logic [15:0] visited;
  int          n_chk = 0, n_fail = 0;
  logic [31:0] sb [$];
  typedef struct {
    logic        v;
    logic [3:0]  s;
    logic [15:0] vis;
    logic [7:0]  tc;
    logic        ill;
    logic        stk;
  } vec_t;
  vec_t tbl [10];
  always #5 clk = ~clk;
  fsm_trace_monitor dut (
    .clk       (clk),
    .rst       (rst),
    .st_valid  (st_valid),
    .st        (st),
    .clear     (clear),
    .rd_req    (rd_req),
    .rd_idx    (rd_idx),
    .rd_ack    (rd_ack),
    .rd_count  (rd_count),
    .visited   (visited),
    .illegal   (illegal),
    .stuck     (stuck),
    .trans_cnt (trans_cnt)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk)
    if (!rst && rd_ack) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL rd_ack_unexpected: got ack with no pending read, count %0h", rd_count);
      end else begin
        logic [31:0] e;
        e = sb.pop_front();
        chk("rd_count", 32'(rd_count), e);
      end
    end
  task automatic rd(input logic [3:0] idx, input logic [31:0] exp);
    sb.push_back(exp);
    rd_req = 1;
    rd_idx = idx;
    step();
    chk("rd_ack_look", 32'(rd_ack), 0);
    rd_idx = idx ^ 4'hF;
    step();
    chk("rd_ack_pulse", 32'(rd_ack), 1);
    rd_req = 0;
    step();
    chk("rd_ack_drop", 32'(rd_ack), 0);
    chk("rd_count_hold", 32'(rd_count), exp);
  endtask
  task automatic apply(input int i);
    st_valid = tbl[i].v;
    st       = tbl[i].s;
    step();
    chk($sformatf("visited[%0d]", i), 32'(visited), 32'(tbl[i].vis));
    chk($sformatf("trans[%0d]", i), 32'(trans_cnt), 32'(tbl[i].tc));
    chk($sformatf("illegal[%0d]", i), 32'(illegal), 32'(tbl[i].ill));
    chk($sformatf("stuck[%0d]", i), 32'(stuck), 32'(tbl[i].stk));
  endtask
  initial begin
    tbl[0] = '{1'b1, 4'd1, 16'h0002, 8'd0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 4'd2, 16'h0006, 8'd1, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 4'd4, 16'h0016, 8'd2, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 4'd2, 16'h0016, 8'd3, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 4'd3, 16'h001E, 8'd4, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 4'd1, 16'h001E, 8'd5, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 4'd9, 16'h001E, 8'd5, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 4'd9, 16'h021E, 8'd6, 1'b1, 1'b0};
    tbl[8] = '{1'b1, 4'd1, 16'h021E, 8'd7, 1'b1, 1'b0};
    tbl[9] = '{1'b1, 4'd6, 16'h025E, 8'd8, 1'b1, 1'b0};
    step();
    step();
    rst = 0;
    step();
    chk("rst_visited", 32'(visited), 0);
    chk("rst_trans", 32'(trans_cnt), 0);
    chk("rst_illegal", 32'(illegal), 0);
    chk("rst_stuck", 32'(stuck), 0);
    chk("rst_rd_ack", 32'(rd_ack), 0);
    chk("rst_rd_count", 32'(rd_count), 0);
    for (int i = 0; i < 6; i++) apply(i);
    st_valid = 0;
    rd(4'd2, 2);
    rd(4'd1, 2);
    rd(4'd0, 0);
    for (int i = 6; i < 10; i++) apply(i);
    st_valid = 0;
    rd(4'd9, 1);
    rd(4'd1, 3);
    // clear beats a same-cycle valid sample
    clear = 1;
    st_valid = 1;
    st = 4'd5;
    step();
    clear = 0;
    st_valid = 0;
    chk("clr_visited", 32'(visited), 0);
    chk("clr_trans", 32'(trans_cnt), 0);
    chk("clr_illegal", 32'(illegal), 0);
    chk("clr_stuck", 32'(stuck), 0);
    rd(4'd1, 0);
    rd(4'd5, 0);
    st_valid = 1;
    step();
    st_valid = 0;
    chk("post_clr_visited", 32'(visited), 32'h0020);
    chk("post_clr_trans", 32'(trans_cnt), 0);
    rd(4'd5, 1);
    // stuck: 7 samples of 4 with gaps stay clear, the 8th sets it
    clear = 1;
    step();
    clear = 0;
    st = 4'd4;
    for (int i = 1; i <= 7; i++) begin
      st_valid = 1;
      step();
      st_valid = 0;
      step();
      chk($sformatf("stuck_pre%0d", i), 32'(stuck), 0);
    end
    st_valid = 1;
    step();
    st_valid = 0;
    chk("stuck_8", 32'(stuck), 1);
    chk("stuck_visited", 32'(visited), 32'h0010);
    chk("stuck_trans", 32'(trans_cnt), 0);
    rd(4'd4, 1);
    // saturation
    clear = 1;
    step();
    clear = 0;
    for (int i = 0; i < 300; i++) begin
      st_valid = 1;
      st = 4'd1;
      step();
      st = 4'd2;
      step();
      if (i == 99) chk("trans_mid", 32'(trans_cnt), 199);
    end
    st_valid = 0;
    chk("sat_trans", 32'(trans_cnt), 255);
    chk("sat_stuck", 32'(stuck), 0);
    rd(4'd1, 255);
    rd(4'd2, 255);
    // reset in the middle of a read: no ack
    rd_req = 1;
    rd_idx = 4'd1;
    step();
    rd_req = 0;
    rst = 1;
    step();
    chk("midrd_ack0", 32'(rd_ack), 0);
    rst = 0;
    step();
    chk("midrd_ack1", 32'(rd_ack), 0);
    step();
    chk("midrd_ack2", 32'(rd_ack), 0);
    chk("midrd_visited", 32'(visited), 0);
    chk("midrd_trans", 32'(trans_cnt), 0);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
